// File: rtl/data_mem_ctrl.sv
// Word-addressed data memory with valid/ready requests, byte-enable stores,
// 1- or 2-cycle response latency, out-of-range errors and a post-reset fill sweep.
module data_mem_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int RD_LAT   = 1,
  parameter int INIT_SEQ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DATA_W/8-1:0]   req_be,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam int BYTES = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_L  = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state_q;
  logic [ADDR_W:0]     cnt_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic                in_range;
  logic                load_hit;
  logic [DATA_W-1:0]   rdata_p0_d;

  logic                vld_p0_q;
  logic                err_p0_q;
  logic [DATA_W-1:0]   rdata_p0_q;

  logic                vld_out;
  logic                err_out;
  logic [DATA_W-1:0]   rdata_out;

  function automatic logic [DATA_W-1:0] fill_word(input logic [ADDR_W:0] idx);
    if (INIT_SEQ != 0) return DATA_W'(idx);
    return '0;
  endfunction

  assign req_ready  = (state_q == ST_RUN);
  assign init_done  = (state_q == ST_RUN);
  assign accept     = req_valid & req_ready;
  assign in_range   = ({1'b0, req_addr} < DEPTH_L);
  assign load_hit   = accept & ~req_we & in_range;
  assign rdata_p0_d = load_hit ? mem[req_addr] : '0;

  // cnt is one bit wider than the address so DEPTH = 2**ADDR_W ends cleanly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + (ADDR_W+1)'(1);
          if (cnt_q == LAST_L) state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // The array is never reset; the sweep rewrites every word instead
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[cnt_q[ADDR_W-1:0]] <= fill_word(cnt_q);
    end else if (accept && req_we && in_range) begin
      for (int k = 0; k < BYTES; k++) begin
        if (req_be[k]) mem[req_addr][8*k +: 8] <= req_wdata[8*k +: 8];
      end
    end
  end

  // Stage p0: registered on the accept edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
      err_p0_q <= 1'b0;
    end else begin
      vld_p0_q <= accept;
      err_p0_q <= accept & ~in_range;
    end
  end

  always_ff @(posedge clk) begin
    rdata_p0_q <= rdata_p0_d;
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              vld_p1_q;
      logic              err_p1_q;
      logic [DATA_W-1:0] rdata_p1_q;

      // Stage p1: extra delay for two-cycle latency
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_p1_q <= 1'b0;
          err_p1_q <= 1'b0;
        end else begin
          vld_p1_q <= vld_p0_q;
          err_p1_q <= err_p0_q;
        end
      end

      always_ff @(posedge clk) begin
        rdata_p1_q <= rdata_p0_q;
      end

      assign vld_out   = vld_p1_q;
      assign err_out   = err_p1_q;
      assign rdata_out = rdata_p1_q;
    end else begin : g_lat1
      assign vld_out   = vld_p0_q;
      assign err_out   = err_p0_q;
      assign rdata_out = rdata_p0_q;
    end
  endgenerate

  // Data registers carry no reset, so the outputs are qualified by valid
  assign rsp_valid = vld_out;
  assign rsp_err   = vld_out & err_out;
  assign rsp_rdata = vld_out ? rdata_out : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (256 deep / latency 1 and 200 deep / latency 2)
// driven by directed and random requests and compared against a behavioural model.
module tb_data_mem_ctrl;

  logic             clk = 1'b0;
  logic [1:0]       rst;
  logic [1:0]       req_valid, req_we;
  logic [1:0][1:0]  req_be;
  logic [1:0][7:0]  req_addr;
  logic [1:0][15:0] req_wdata;
  logic [1:0]       req_ready, rsp_valid, rsp_err, init_done;
  logic [1:0][15:0] rsp_rdata;

  int n_chk = 0;
  int n_pass = 0;

  // Model state
  int          E = 0;
  int          cnt [2];
  logic [15:0] mm [2][256];
  logic        pv [2][4];
  logic        pe [2][4];
  logic [15:0] pd [2][4];

  // Last observed response per instance
  logic        rcv_v [2];
  logic        rcv_e [2];
  logic [15:0] rcv_d [2];

  always #5 clk = ~clk;

  data_mem_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .RD_LAT(1), .INIT_SEQ(1)) u_dut_a (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_be(req_be[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .init_done(init_done[0]));

  data_mem_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .RD_LAT(2), .INIT_SEQ(1)) u_dut_b (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_be(req_be[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .init_done(init_done[1]));

  function automatic int dep(input int d);
    return (d == 0) ? 256 : 200;
  endfunction

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_edge(input int d);
    int s;
    int a;
    logic rdy, inr;
    if (rst[d]) begin
      cnt[d] = 0;
      for (int i = 0; i < 4; i++) pv[d][i] = 1'b0;
      for (int i = 0; i < 256; i++) mm[d][i] = 16'(i);
    end else begin
      rdy = (cnt[d] >= dep(d));
      if (!rdy) cnt[d]++;
      if (req_valid[d] && rdy) begin
        a   = int'(req_addr[d]);
        inr = (a < dep(d));
        s   = (E + lat(d) - 1) % 4;
        if (req_we[d] && inr) begin
          for (int k = 0; k < 2; k++)
            if (req_be[d][k]) mm[d][a][8*k +: 8] = req_wdata[d][8*k +: 8];
        end
        pv[d][s] = 1'b1;
        pe[d][s] = !inr;
        pd[d][s] = (!req_we[d] && inr) ? mm[d][a] : 16'h0000;
      end
    end
  endtask

  task automatic step();
    int s;
    logic ev, ee;
    logic [15:0] ed;
    logic er;
    @(posedge clk);
    E++;
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    s = E % 4;
    for (int d = 0; d < 2; d++) begin
      ev = pv[d][s];
      ee = ev ? pe[d][s] : 1'b0;
      ed = ev ? pd[d][s] : 16'h0000;
      er = (cnt[d] >= dep(d));
      chk($sformatf("d%0d_vld_e%0d", d, E), 32'(rsp_valid[d]), 32'(ev));
      chk($sformatf("d%0d_err_e%0d", d, E), 32'(rsp_err[d]), 32'(ee));
      chk($sformatf("d%0d_rdata_e%0d", d, E), 32'(rsp_rdata[d]), 32'(ed));
      chk($sformatf("d%0d_ready_e%0d", d, E), 32'(req_ready[d]), 32'(er));
      chk($sformatf("d%0d_idone_e%0d", d, E), 32'(init_done[d]), 32'(er));
      pv[d][s] = 1'b0;
      rcv_v[d] = rsp_valid[d];
      rcv_e[d] = rsp_err[d];
      rcv_d[d] = rsp_rdata[d];
    end
  endtask

  task automatic set_req(input int d, input logic we, input logic [1:0] be,
                         input logic [7:0] addr, input logic [15:0] wd);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_be[d]    = be;
    req_addr[d]  = addr;
    req_wdata[d] = wd;
  endtask

  task automatic txn(input int d, input logic we, input logic [1:0] be,
                     input logic [7:0] addr, input logic [15:0] wd);
    set_req(d, we, be, addr, wd);
    step();
    req_valid[d] = 1'b0;
    for (int i = 1; i < lat(d); i++) step();
  endtask

  initial begin
    int n, nb;
    for (int d = 0; d < 2; d++) begin
      cnt[d] = 0;
      for (int i = 0; i < 4; i++) begin
        pv[d][i] = 1'b0; pe[d][i] = 1'b0; pd[d][i] = 16'h0000;
      end
    end
    rst = 2'b00;
    req_valid = '0; req_we = '0; req_be = '0; req_addr = '0; req_wdata = '0;
    #1 rst = 2'b11;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_rst_vld", d), 32'(rsp_valid[d]), 32'd0);
      chk($sformatf("d%0d_rst_rdy", d), 32'(req_ready[d]), 32'd0);
      chk($sformatf("d%0d_rst_idone", d), 32'(init_done[d]), 32'd0);
    end
    // Store request held through the whole sweep must be ignored
    set_req(0, 1'b1, 2'b11, 8'd0, 16'hFFFF);
    set_req(1, 1'b1, 2'b11, 8'd0, 16'hFFFF);
    repeat (3) step();
    rst = 2'b00;
    n = 0; nb = 0;
    while (!init_done[0] && n < 1000) begin
      step();
      n++;
      if (init_done[1] && nb == 0) nb = n;
      for (int d = 0; d < 2; d++) if (init_done[d]) req_valid[d] = 1'b0;
    end
    chk("init_edges_a", 32'(n), 32'd256);
    chk("init_edges_b", 32'(nb), 32'd200);

    txn(0, 1'b0, 2'b00, 8'd0, 16'h0);
    chk("gate_a0", 32'(rcv_d[0]), 32'h0000);
    txn(1, 1'b0, 2'b00, 8'd0, 16'h0);
    chk("gate_b0", 32'(rcv_d[1]), 32'h0000);
    txn(0, 1'b0, 2'b00, 8'd5, 16'h0);
    chk("ld5", 32'(rcv_d[0]), 32'h0005);
    txn(0, 1'b0, 2'b00, 8'd255, 16'h0);
    chk("ld255", 32'(rcv_d[0]), 32'h00FF);
    chk("ld255_err", 32'(rcv_e[0]), 32'd0);

    txn(0, 1'b1, 2'b10, 8'd3, 16'hABCD);
    txn(0, 1'b0, 2'b00, 8'd3, 16'h0);
    chk("be_vld", 32'(rcv_v[0]), 32'd1);
    chk("be_data", 32'(rcv_d[0]), 32'hAB03);

    set_req(1, 1'b1, 2'b11, 8'd7, 16'h1234);
    step();
    set_req(1, 1'b0, 2'b00, 8'd7, 16'h0);
    step();
    chk("b2b_st_vld", 32'(rcv_v[1]), 32'd1);
    req_valid[1] = 1'b0;
    step();
    chk("b2b_ld_vld", 32'(rcv_v[1]), 32'd1);
    chk("b2b_ld_data", 32'(rcv_d[1]), 32'h1234);

    txn(1, 1'b1, 2'b11, 8'd210, 16'h5555);
    chk("oor_st_err", 32'(rcv_e[1]), 32'd1);
    chk("oor_st_data", 32'(rcv_d[1]), 32'd0);
    txn(1, 1'b0, 2'b00, 8'd210, 16'h0);
    chk("oor_ld_err", 32'(rcv_e[1]), 32'd1);
    chk("oor_ld_data", 32'(rcv_d[1]), 32'd0);
    txn(1, 1'b0, 2'b00, 8'd199, 16'h0);
    chk("ld199_data", 32'(rcv_d[1]), 32'h00C7);
    chk("ld199_err", 32'(rcv_e[1]), 32'd0);

    txn(1, 1'b1, 2'b11, 8'd3, 16'hBEEF);
    txn(1, 1'b0, 2'b00, 8'd3, 16'h0);
    chk("pre_rst_ld3", 32'(rcv_d[1]), 32'hBEEF);
    set_req(1, 1'b0, 2'b00, 8'd5, 16'h0);
    step();
    req_valid[1] = 1'b0;
    rst[1] = 1'b1;
    #1;
    chk("mid_rst_vld", 32'(rsp_valid[1]), 32'd0);
    chk("mid_rst_rdy", 32'(req_ready[1]), 32'd0);
    chk("mid_rst_idone", 32'(init_done[1]), 32'd0);
    step();
    chk("mid_rst_drop", 32'(rcv_v[1]), 32'd0);
    step();
    rst[1] = 1'b0;
    n = 0;
    while (!init_done[1] && n < 1000) begin
      step();
      n++;
    end
    chk("reinit_edges_b", 32'(n), 32'd200);
    txn(1, 1'b0, 2'b00, 8'd3, 16'h0);
    chk("post_rst_ld3", 32'(rcv_d[1]), 32'h0003);

    repeat (400) begin
      for (int d = 0; d < 2; d++) begin
        req_valid[d] = ($urandom_range(0, 3) != 0);
        req_we[d]    = 1'($urandom_range(0, 1));
        req_be[d]    = 2'($urandom_range(0, 3));
        req_addr[d]  = 8'($urandom_range(0, 255));
        req_wdata[d] = 16'($urandom);
      end
      step();
    end
    req_valid = '0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
